// File: rtl/dbus_ctrl.sv
// Data-bus controller: maps CPU loads/stores onto one single-port SRAM and a 256-word MMIO page,
// with a posted write buffer. Optional cycle counter under `define DBUS_CYCLE_COUNTER_EN.
module dbus_ctrl #(
  parameter int unsigned MEM_AWIDTH = 14,
  parameter int unsigned WB_DEPTH   = 4,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic [15:0]           cpu_raddr,
  output logic [15:0]           cpu_rdata,
  input  logic                  cpu_we,
  input  logic [15:0]           cpu_waddr,
  input  logic [15:0]           cpu_wdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic [15:0]           gpio_out,
  output logic                  wb_overflow
);

  localparam int unsigned PW = $clog2(WB_DEPTH);

  typedef logic [PW:0] ptr_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_MEM, SEL_FWD, SEL_MMIO} rsel_e;

  logic [MEM_AWIDTH-1:0] wb_addr [WB_DEPTH];
  logic [15:0]           wb_data [WB_DEPTH];
  ptr_t                  rd_ptr, wr_ptr, count;
  logic [PW-1:0]         idx;

  logic        rd_mmio, wr_mmio, ram_rd, ram_wr;
  logic        empty, full, pop, push, drop;
  logic        fwd_match;
  logic [15:0] fwd_val, fwd_data;
  logic [15:0] mmio_rd_val, mmio_q;
  logic [7:0]  rd_off, wr_off;
  rsel_e       rsel_d, rsel_q;

  // Region decode
  assign rd_mmio = (cpu_raddr[15:8] == MMIO_BASE[15:8]);
  assign wr_mmio = (cpu_waddr[15:8] == MMIO_BASE[15:8]);
  assign rd_off  = cpu_raddr[7:0];
  assign wr_off  = cpu_waddr[7:0];
  assign ram_rd  = cpu_re && !rd_mmio;
  assign ram_wr  = cpu_we && !wr_mmio;

  // Buffer status; pointers carry one extra wrap bit to tell full from empty
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[PW] != wr_ptr[PW]) && (rd_ptr[PW-1:0] == wr_ptr[PW-1:0]);

  // A RAM read always owns the port; the buffer drains only in cycles without one
  assign pop  = !ram_rd && !empty;
  assign push = ram_wr && (!full || pop);
  assign drop = ram_wr && full && !pop;

  assign mem_en    = rst && (ram_rd || pop);
  assign mem_we    = rst && pop;
  assign mem_addr  = ram_rd ? cpu_raddr[MEM_AWIDTH-1:0] : wb_addr[rd_ptr[PW-1:0]];
  assign mem_wdata = wb_data[rd_ptr[PW-1:0]];

  // Forwarding search walks oldest to newest so the newest matching entry wins
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fwd_match = 1'b0;
    fwd_val   = '0;
    idx       = '0;
    count     = wr_ptr - rd_ptr;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = rd_ptr[PW-1:0] + PW'(i);
      if ((ptr_t'(i) < count) && (wb_addr[idx] == cpu_raddr[MEM_AWIDTH-1:0])) begin
        fwd_match = 1'b1;
        fwd_val   = wb_data[idx];
      end
    end
  end

  // NOTE: buffer storage has no reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr[PW-1:0]] <= cpu_waddr[MEM_AWIDTH-1:0];
      wb_data[wr_ptr[PW-1:0]] <= cpu_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      wb_overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (drop) wb_overflow <= 1'b1;
    end
  end

`ifdef DBUS_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt;
  logic [15:0] cyc_snap;

  // Reading the low half freezes the high half so a follow-up read is coherent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt  <= '0;
      cyc_snap <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (cpu_re && rd_mmio && (rd_off == 8'h01)) cyc_snap <= cyc_cnt[31:16];
    end
  end
`endif

  always_comb begin
    mmio_rd_val = '0;
    case (rd_off)
      8'h00:   mmio_rd_val = gpio_out;
`ifdef DBUS_CYCLE_COUNTER_EN
      8'h01:   mmio_rd_val = cyc_cnt[15:0];
      8'h02:   mmio_rd_val = cyc_snap;
`endif
      default: mmio_rd_val = '0;
    endcase
  end

  always_comb begin
    rsel_d = SEL_NONE;
    if (cpu_re && rd_mmio) rsel_d = SEL_MMIO;
    else if (ram_rd)       rsel_d = fwd_match ? SEL_FWD : SEL_MEM;
    else if (pop)          rsel_d = SEL_MEM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out <= '0;
      rsel_q   <= SEL_NONE;
      fwd_data <= '0;
      mmio_q   <= '0;
    end else begin
      if (cpu_we && wr_mmio && (wr_off == 8'h00)) gpio_out <= cpu_wdata;
      rsel_q <= rsel_d;
      if (ram_rd && fwd_match) fwd_data <= fwd_val;
      if (cpu_re && rd_mmio)   mmio_q   <= mmio_rd_val;
    end
  end

  // Read data lines up with the CPU's capture one cycle after cpu_re
  always_comb begin
    cpu_rdata = '0;
    case (rsel_q)
      SEL_MEM:  cpu_rdata = mem_rdata;
      SEL_FWD:  cpu_rdata = fwd_data;
      SEL_MMIO: cpu_rdata = mmio_q;
      default:  cpu_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed self-checking bench for dbus_ctrl with a behavioural single-port SRAM.
module tb_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [15:0] cpu_raddr, cpu_waddr, cpu_wdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] gpio_out;
  logic        wb_overflow;

  logic [15:0] sram [2**14];
  logic [15:0] dv [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dbus_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .gpio_out(gpio_out), .wb_overflow(wb_overflow)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic re, input logic [15:0] ra, input logic we,
                       input logic [15:0] wa, input logic [15:0] wd);
    cpu_re = re; cpu_raddr = ra; cpu_we = we; cpu_waddr = wa; cpu_wdata = wd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2**14; i++) sram[i] = '0;
    mem_rdata = '0;
    rst = 1'b0;
    idle();
    @(negedge clk);
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_gpio", 32'(gpio_out), 32'd0);
    check("rst_ovf", 32'(wb_overflow), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;

    // Buffered write drains one cycle later, then reads back from SRAM
    drive(1'b0, 16'h0, 1'b1, 16'h0010, 16'h1234);
    check("t1_wr_no_port", 32'(mem_en), 32'd0);
    step();
    idle();
    check("t1_pop_en", 32'(mem_en), 32'd1);
    check("t1_pop_we", 32'(mem_we), 32'd1);
    check("t1_pop_addr", 32'(mem_addr), 32'h10);
    check("t1_pop_data", 32'(mem_wdata), 32'h1234);
    step();
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    check("t1_rd_we", 32'(mem_we), 32'd0);
    check("t1_rd_addr", 32'(mem_addr), 32'h10);
    step();
    idle();
    check("t1_rdata", 32'(cpu_rdata), 32'h1234);
    check("t1_empty", 32'(mem_en), 32'd0);
    step();

    // Read right behind a write is served by forwarding
    drive(1'b0, 16'h0, 1'b1, 16'h0020, 16'hA5A5);
    step();
    drive(1'b1, 16'h0020, 1'b0, 16'h0, 16'h0);
    check("t2_rd_no_write", 32'(mem_we), 32'd0);
    step();
    idle();
    check("t2_fwd", 32'(cpu_rdata), 32'hA5A5);
    check("t2_drain_we", 32'(mem_we), 32'd1);
    check("t2_drain_addr", 32'(mem_addr), 32'h20);
    step();

    // Two buffered writes to one address: newest wins
    drive(1'b1, 16'h0100, 1'b1, 16'h0030, 16'h0005);
    step();
    drive(1'b1, 16'h0100, 1'b1, 16'h0030, 16'h0006);
    check("t3_sram_rd", 32'(cpu_rdata), 32'd0);
    step();
    drive(1'b1, 16'h0030, 1'b0, 16'h0, 16'h0);
    step();
    idle();
    check("t3_newest", 32'(cpu_rdata), 32'h6);
    check("t3_pop1", 32'(mem_wdata), 32'h5);
    step();
    idle();
    check("t3_pop2", 32'(mem_wdata), 32'h6);
    step();
    check("t3_empty", 32'(mem_en), 32'd0);

    // Fill while reads hold the port; full push+pop; then overflow
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0200, 1'b1, 16'h0040 + 16'(i), dv[i]);
      check("t4_fill_no_we", 32'(mem_we), 32'd0);
      step();
    end
    check("t4_full_no_ovf", 32'(wb_overflow), 32'd0);
    drive(1'b0, 16'h0, 1'b1, 16'h0044, dv[4]);
    check("t4_fullpp_addr", 32'(mem_addr), 32'h40);
    check("t4_fullpp_data", 32'(mem_wdata), 32'(dv[0]));
    step();
    check("t4_pp_no_ovf", 32'(wb_overflow), 32'd0);
    drive(1'b1, 16'h0200, 1'b1, 16'h0045, dv[5]);
    step();
    check("t4_ovf", 32'(wb_overflow), 32'd1);
    for (int i = 1; i < 5; i++) begin
      idle();
      check("t4_drain_we", 32'(mem_we), 32'd1);
      check("t4_drain_addr", 32'(mem_addr), 32'h40 + 32'(i));
      check("t4_drain_data", 32'(mem_wdata), 32'(dv[i]));
      step();
    end
    idle();
    check("t4_drained", 32'(mem_en), 32'd0);
    check("t4_dropped", 32'(sram[14'h45]), 32'd0);
    check("t4_ovf_sticky", 32'(wb_overflow), 32'd1);

    // MMIO page
    drive(1'b0, 16'h0, 1'b1, 16'hFF00, 16'hBEEF);
    check("t5_wr_no_port", 32'(mem_en), 32'd0);
    step();
    check("t5_gpio", 32'(gpio_out), 32'hBEEF);
    drive(1'b1, 16'hFF00, 1'b0, 16'h0, 16'h0);
    check("t5_rd_no_port", 32'(mem_en), 32'd0);
    step();
    drive(1'b1, 16'hFF07, 1'b1, 16'hFF05, 16'h1111);
    check("t5_rd_gpio", 32'(cpu_rdata), 32'hBEEF);
    step();
    drive(1'b1, 16'hFF00, 1'b1, 16'hFF00, 16'h1357);
    check("t5_rd_ff07", 32'(cpu_rdata), 32'd0);
    check("t5_wr_ff05_ign", 32'(gpio_out), 32'hBEEF);
    step();
    drive(1'b1, 16'hFF01, 1'b0, 16'h0, 16'h0);
    check("t5_pre_write", 32'(cpu_rdata), 32'hBEEF);
    check("t5_gpio2", 32'(gpio_out), 32'h1357);
    step();
    idle();
`ifndef DBUS_CYCLE_COUNTER_EN
    check("t5_ff01_zero", 32'(cpu_rdata), 32'd0);
`endif
    step();

    // Same-cycle RAM read/write returns old data; aliasing above MEM_AWIDTH
    drive(1'b1, 16'h0030, 1'b1, 16'h0030, 16'h7777);
    step();
    idle();
    check("t6_old_value", 32'(cpu_rdata), 32'h6);
    check("t6_pop_data", 32'(mem_wdata), 32'h7777);
    step();
    drive(1'b1, 16'h4030, 1'b0, 16'h0, 16'h0);
    check("t6_alias_addr", 32'(mem_addr), 32'h30);
    step();
    idle();
    check("t6_alias_data", 32'(cpu_rdata), 32'h7777);
    step();

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0200, 1'b1, 16'h0050 + 16'(i), dv[i]);
      step();
    end
    idle();
    check("t7_draining", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("t7_rst_en", 32'(mem_en), 32'd0);
    check("t7_rst_we", 32'(mem_we), 32'd0);
    check("t7_rst_ovf", 32'(wb_overflow), 32'd0);
    check("t7_rst_gpio", 32'(gpio_out), 32'd0);
    check("t7_rst_rdata", 32'(cpu_rdata), 32'd0);
    step();
    rst = 1'b1;
    #1;
    check("t7_empty", 32'(mem_en), 32'd0);
    step();
    check("t7_still_empty", 32'(mem_en), 32'd0);
    check("t7_not_written", 32'(sram[14'h51]), 32'd0);

`ifdef DBUS_CYCLE_COUNTER_EN
    // One posedge since release so far; two more make the counter 3 at the read
    step();
    step();
    drive(1'b1, 16'hFF01, 1'b0, 16'h0, 16'h0);
    step();
    drive(1'b1, 16'hFF02, 1'b0, 16'h0, 16'h0);
    check("t8_cnt_low", 32'(cpu_rdata), 32'd3);
    step();
    idle();
    check("t8_cnt_snap", 32'(cpu_rdata), 32'd0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
- Data-bus controller directly downstream of the cpu data port (re/raddr/rdata, we/waddr/wdata).
- Maps CPU data accesses onto one single-port synchronous SRAM and a small MMIO page.
- Posted writes go through a write buffer so a CPU read always owns the SRAM port. Read data is returned exactly one cycle after re, matching the CPU's LOAD1 capture.

Parameters:
MEM_AWIDTH, 14, SRAM word-address width; RAM region aliases modulo 2^MEM_AWIDTH
WB_DEPTH, 4, write-buffer entries (power of two, >=2)
MMIO_BASE, 16'hFF00, first address of the 256-word MMIO page (addr[15:8]==MMIO_BASE[15:8])

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
cpu_re  in  1  read strobe, one cycle per load
cpu_raddr  in  16  read word address
cpu_rdata  out  16  read data, valid the cycle after cpu_re
cpu_we  in  1  write strobe
cpu_waddr  in  16  write word address
cpu_wdata  in  16  write data
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable (qualified by mem_en)
mem_addr  out  MEM_AWIDTH  SRAM address
mem_wdata  out  16  SRAM write data
mem_rdata  in  16  SRAM read data, one cycle after mem_en&!mem_we
gpio_out  out  16  MMIO output register
wb_overflow  out  1  sticky: a RAM write was dropped

Behaviour:
- Reset (rst low, async): buffer empty, rd/wr pointers 0, gpio_out=0, wb_overflow=0, fwd/sel regs cleared, cpu_rdata=0. mem_en=0 and mem_we=0 combinationally while in reset.
- Region decode: MMIO if addr[15:8]==MMIO_BASE[15:8], else RAM using addr[MEM_AWIDTH-1:0].
- Port arbitration, per cycle, priority order:
  - (1) cpu_re to RAM: mem_en=1, mem_we=0, mem_addr=raddr.
  - (2) else buffer non-empty: pop oldest entry; mem_en=1, mem_we=1.
  - (3) else mem_en=0.
- RAM writes: always pushed at the tail on cpu_we, never sent direct to SRAM. Minimum write-to-SRAM latency is 1 cycle.
- Push and pop in the same cycle are legal, including when full.
- Full, push requested, no pop this cycle (a read owns the port): the write is dropped, wb_overflow set, stays set until reset.
- Forwarding: on a RAM read, compare raddr (MEM_AWIDTH bits) against all valid buffer entries as they stand before this cycle's push/pop.
  - Newest match wins: data registered into fwd_data, fwd_hit=1.
  - cpu_rdata next cycle = fwd_hit ? fwd_data : mem_rdata.
- Same-cycle read and write to the same address: the read returns the pre-write value.
- MMIO:
  - Writes take effect at the same clock edge and bypass the buffer.
  - Offset 0x00: gpio_out, R/W.
  - Other offsets: write ignored, read 0.
  - MMIO reads are registered: value appears on cpu_rdata the next cycle; SRAM port is not used.
- Idle cycle (no read in the previous cycle): cpu_rdata = mem_rdata if the previous cycle popped, else 0. The CPU does not sample it.
- Pointers are log2(WB_DEPTH)+1 bits. Full = MSBs differ and low bits equal; empty = pointers equal. Wrap is modulo 2*WB_DEPTH.

Optional Feature:
- Macro DBUS_CYCLE_COUNTER_EN.
- Defined:
  - 32-bit free-running counter, reset 0, increments every cycle, wraps at 2^32.
  - MMIO 0x01 reads the low half and latches the high half into a snapshot register.
  - MMIO 0x02 reads the snapshot, giving a coherent 32-bit value.
  - Writes to 0x01/0x02 are ignored.
- Undefined: no counter or snapshot logic; 0x01/0x02 read 0.

Test Plan:
- Write 0x1234 to 0x0010, idle 1 cycle, read 0x0010 -> mem_we pulse with addr 0x10 one cycle after write; read returns 0x1234 from SRAM.
- Write A to 0x20, then read 0x20 on the next cycle with no idle -> returned via forwarding (fwd_hit) = A, and no SRAM write occurs during the read cycle.
- Writes 5 then 6 to 0x30 back-to-back, immediate read 0x30 -> returns 6 (newest match).
- Fill 4 entries while holding cpu_re every cycle, then a 5th write with re -> wb_overflow=1, 5th value never reaches SRAM; the 4 earlier values drain in order once re drops.
- Write 0xBEEF to 0xFF00, read 0xFF00 -> gpio_out=0xBEEF after the edge; cpu_rdata=0xBEEF next cycle; read 0xFF07 -> 0.
- With DBUS_CYCLE_COUNTER_EN: read 0xFF01 at cycle N after reset -> low = N; read 0xFF02 later -> high half latched at the 0xFF01 read. Assert rst mid-drain -> buffer empty, mem_en=0 immediately.
